ladybird_sys_ctrl: RTL and testbench
====================================

LADYBIRD_SYS_CTRL -- requirements
Module: ladybird_sys_ctrl

Interface
REQ-001 SHALL have parameter N_CORE, default 2, number of cores to wake (1..8).
REQ-002 SHALL have parameter N_BTN, default 4, number of buttons/LEDs (1..8).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (>=2).
REQ-004 SHALL have parameter RST_HOLD, default 16, cycles nrst_o is held low after sync release (>=1).
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 1000, stable cycles needed to accept a button change (>=1).
REQ-006 SHALL have parameter RST_BTN, default 3, button index acting as reset request; value >= N_BTN disables it.
REQ-007 SHALL have parameters START_PC_BASE (32'h8000_0000) and START_PC_STRIDE (32'h0000_1000), per-core start address.
REQ-008 SHALL have parameter HB_LOG2, default 24, heartbeat half-period exponent.
REQ-009 clk_i  in  1  system clock, all flops on rising edge.
REQ-010 anrst_i  in  1  reset, asynchronous, active-low.
REQ-011 btn_i  in  N_BTN  raw asynchronous buttons, active-high.
REQ-012 soft_rst_req_i  in  1  synchronous single-cycle software reset request.
REQ-013 led_mode_i  in  2  LED source select.
REQ-014 nrst_o  out  1  synchronous active-low system reset.
REQ-015 start_o  out  N_CORE  per-core one-cycle wake pulse.
REQ-016 start_pc_o  out  N_CORE x 32  start_pc_o[i] = START_PC_BASE + i*START_PC_STRIDE, constant, modulo 2^32.
REQ-017 btn_db_o  out  N_BTN  debounced button levels.
REQ-018 led_o  out  N_BTN  LED drive.
REQ-019 state_o  out  3  current FSM state code.

Function
REQ-020 SHALL synchronize anrst_i release through SYNC_STAGES flops cleared asynchronously by anrst_i; assertion acts immediately.
REQ-021 SHALL implement FSM: RESET=0, HOLD=1, RELEASE=2, START=3, RUN=4; codes 5-7 unreachable, decode to RESET.
REQ-022 RESET -> HOLD on the edge the synchronizer output first samples high (edge SYNC_STAGES after release); hold counter = 0.
REQ-023 HOLD: counter increments per cycle; after RST_HOLD cycles in HOLD -> RELEASE.
REQ-024 nrst_o SHALL be registered, 0 in RESET/HOLD, 1 in RELEASE/START/RUN.
REQ-025 RELEASE lasts exactly 1 cycle, then START with core index 0.
REQ-026 START: start_o[idx]=1 for one cycle, idx increments each cycle; after idx N_CORE-1 -> RUN; exactly one start_o bit high per START cycle.
REQ-027 start_o SHALL be 0 in all states except START.
REQ-028 In RELEASE/START/RUN, soft_rst_req_i=1 or rising edge of btn_db_o[RST_BTN] SHALL go to HOLD next edge, counter 0, nrst_o=0, remaining start pulses abandoned.
REQ-029 In HOLD, a reset request SHALL restart the counter at 0; in RESET it is ignored.
REQ-030 Simultaneous soft and button requests SHALL count as one request.
REQ-031 Debounce per button: SYNC_STAGES synchronizer; counter clears while synced == btn_db_o; btn_db_o takes synced value after DEBOUNCE_CYCLES consecutive differing cycles; glitches shorter never propagate.
REQ-032 Debounce SHALL run in every FSM state.
REQ-033 Heartbeat counter HB_LOG2+1 bits, free-running, wraps, cleared while nrst_o=0.
REQ-034 led_o by led_mode_i: 0 -> btn_db_o; 1 -> bit0 = heartbeat MSB, others 0; 2 -> state_o zero-extended/truncated to N_BTN; 3 -> bit i = core i started since last nrst_o low (i < min(N_BTN,N_CORE)), others 0.
REQ-035 led_o SHALL be 0 whenever nrst_o=0 regardless of mode.
REQ-036 Counter widths SHALL be $clog2(param+1) bits; no overflow.

Reset
REQ-037 anrst_i low SHALL immediately force: state RESET, nrst_o=0, start_o=0, led_o=0, btn_db_o=0, all counters and synchronizers 0, started mask 0.
REQ-038 anrst_i assertion mid-START or mid-HOLD SHALL abort the sequence; full sequence restarts on release.

Verification (N_CORE=2, N_BTN=4, SYNC_STAGES=2, RST_HOLD=8, DEBOUNCE_CYCLES=4, RST_BTN=3)
REQ-039 Release anrst_i before edge 1 -> state HOLD at edge 2, nrst_o=1 at edge 10, start_o=01 after edge 11, 10 after edge 12, state RUN after edge 13; start_pc_o = 8000_0000, 8000_1000.
REQ-040 btn_i[0] high 3 cycles then low -> btn_db_o[0] stays 0; high 6 cycles -> btn_db_o[0]=1 after sync+4 cycles; led_o[0]=1 in mode 0.
REQ-041 In RUN, soft_rst_req_i pulse -> nrst_o=0 next edge, 8-cycle HOLD, start pulses repeat; btn_i[3] held -> same once debounced, no repeat while held.
REQ-042 soft_rst_req_i on cycle start_o=01 -> start_o[1] never pulses; HOLD restarts; mode 3 LEDs cleared.
REQ-043 anrst_i low during HOLD cycle 5 -> outputs zero asynchronously; release -> full 2+8 cycle sequence.
REQ-044 led_mode_i=2 in RUN -> led_o=0100; mode 3 after start -> 0011; mode 1 with HB_LOG2=2 -> led_o[0] toggles every 4 cycles.

Source files
------------

// File: rtl/ladybird_sys_ctrl_if.sv
// Board- and core-facing signal bundle of the Ladybird system controller.
// The controller takes the slave side; the board/bench drives the master side.
interface ladybird_sys_ctrl_if #(
    parameter int unsigned N_CORE = 2,
    parameter int unsigned N_BTN  = 4
);
    logic [N_BTN-1:0]        btn_i;
    logic                    soft_rst_req_i;
    logic [1:0]              led_mode_i;
    logic                    nrst_o;
    logic [N_CORE-1:0]       start_o;
    logic [N_CORE-1:0][31:0] start_pc_o;
    logic [N_BTN-1:0]        btn_db_o;
    logic [N_BTN-1:0]        led_o;
    logic [2:0]              state_o;

    modport master (
        output btn_i, soft_rst_req_i, led_mode_i,
        input  nrst_o, start_o, start_pc_o, btn_db_o, led_o, state_o
    );

    modport slave (
        input  btn_i, soft_rst_req_i, led_mode_i,
        output nrst_o, start_o, start_pc_o, btn_db_o, led_o, state_o
    );
endinterface

// File: rtl/ladybird_sys_ctrl.sv
// Ladybird system controller: reset release sequencing, per-core wake pulses,
// button debouncing, and LED source selection.
module ladybird_sys_ctrl #(
    parameter int unsigned N_CORE          = 2,
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned RST_HOLD        = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned RST_BTN         = 3,
    parameter logic [31:0] START_PC_BASE   = 32'h8000_0000,
    parameter logic [31:0] START_PC_STRIDE = 32'h0000_1000,
    parameter int unsigned HB_LOG2         = 24
) (
    input  logic               clk_i,
    input  logic               anrst_i,
    ladybird_sys_ctrl_if.slave bus
);
    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
    localparam int unsigned IDX_W  = $clog2(N_CORE + 1);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_HOLD    = 3'd1,
        S_RELEASE = 3'd2,
        S_START   = 3'd3,
        S_RUN     = 3'd4
    } state_t;

    state_t                            state_q, state_d;
    logic [HOLD_W-1:0]                 hold_q, hold_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic                              nrst_q, nrst_d;
    logic [N_CORE-1:0]                 start, started_q, started_d;
    logic [SYNC_STAGES-1:0]            rsync_q;
    logic [SYNC_STAGES-1:0][N_BTN-1:0] bsync_q;
    logic [N_BTN-1:0]                  btn_db_q, btn_db_d;
    logic [N_BTN-1:0][DB_W-1:0]        dbcnt_q, dbcnt_d;
    logic [HB_LOG2:0]                  hb_q;
    logic [N_BTN-1:0]                  led;
    logic                              sync_rel, btn_rise, rst_req;

    // Reset-release synchronizer; assertion clears it immediately.
    always_ff @(posedge clk_i or negedge anrst_i) begin
        if (!anrst_i) rsync_q <= '0;
        else          rsync_q <= {rsync_q[SYNC_STAGES-2:0], 1'b1};
    end

    // Leave RESET on the edge the last stage first captures a one; the last
    // stage itself also counts so an illegal state code still recovers.
    assign sync_rel = rsync_q[SYNC_STAGES-2] | rsync_q[SYNC_STAGES-1];

    // Button synchronizers, debounced levels and stability counters.
    always_ff @(posedge clk_i or negedge anrst_i) begin
        if (!anrst_i) begin
            bsync_q  <= '0;
            btn_db_q <= '0;
            dbcnt_q  <= '0;
        end else begin
            bsync_q  <= {bsync_q[SYNC_STAGES-2:0], bus.btn_i};
            btn_db_q <= btn_db_d;
            dbcnt_q  <= dbcnt_d;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        btn_db_d = btn_db_q;
        dbcnt_d  = dbcnt_q;
        for (int i = 0; i < N_BTN; i++) begin
            if (bsync_q[SYNC_STAGES-1][i] == btn_db_q[i]) begin
                dbcnt_d[i] = '0;
            end else if (dbcnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db_d[i] = bsync_q[SYNC_STAGES-1][i];
                dbcnt_d[i]  = '0;
            end else begin
                dbcnt_d[i] = dbcnt_q[i] + DB_W'(1);
            end
        end
    end

    generate
        if (RST_BTN < N_BTN) begin : g_rst_btn
            logic prev_q;
            // Previous debounced reset-button level for rising-edge detection.
            always_ff @(posedge clk_i or negedge anrst_i) begin
                if (!anrst_i) prev_q <= 1'b0;
                else          prev_q <= btn_db_q[RST_BTN];
            end
            assign btn_rise = btn_db_q[RST_BTN] & ~prev_q;
        end else begin : g_no_rst_btn
            assign btn_rise = 1'b0;
        end
    endgenerate

    // Software and button requests merge into a single request.
    assign rst_req = bus.soft_rst_req_i | btn_rise;

    // Sequencer state, counters, system reset and started-core mask.
    always_ff @(posedge clk_i or negedge anrst_i) begin
        if (!anrst_i) begin
            state_q   <= S_RESET;
            hold_q    <= '0;
            idx_q     <= '0;
            nrst_q    <= 1'b0;
            started_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            idx_q     <= idx_d;
            nrst_q    <= nrst_d;
            started_q <= started_d;
        end
    end

    // Next-state logic; codes 5-7 fall into the RESET branch.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        case (state_q)
            S_HOLD: begin
                if (rst_req) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
                    state_d = S_RELEASE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_RELEASE: begin
                if (rst_req) begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                end else begin
                    state_d = S_START;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (rst_req) begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                    idx_d   = '0;
                end else if (idx_q == IDX_W'(N_CORE - 1)) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_RUN: begin
                if (rst_req) begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                end
            end
            default: begin
                if (sync_rel) begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                end
            end
        endcase
        nrst_d    = (state_d == S_RELEASE) || (state_d == S_START) || (state_d == S_RUN);
        started_d = nrst_d ? (started_q | start) : '0;
    end

    // One wake pulse for the core currently indexed while in START.
    always_comb begin
        start = '0;
        for (int i = 0; i < N_CORE; i++) begin
            if ((state_q == S_START) && (idx_q == IDX_W'(i))) start[i] = 1'b1;
        end
    end

    // Free-running heartbeat, held at zero while the system is in reset.
    always_ff @(posedge clk_i or negedge anrst_i) begin
        if (!anrst_i)    hb_q <= '0;
        else if (!nrst_q) hb_q <= '0;
        else             hb_q <= hb_q + 1'b1;
    end

    // LED source select, blanked whenever the system reset is active.
    always_comb begin
        led = '0;
        if (nrst_q) begin
            case (bus.led_mode_i)
                2'd0:    led = btn_db_q;
                2'd1:    led[0] = hb_q[HB_LOG2];
                2'd2:    led = N_BTN'({5'b0, state_q});
                default: led = N_BTN'(8'(started_q));
            endcase
        end
    end

    for (genvar g = 0; g < N_CORE; g++) begin : g_pc
        assign bus.start_pc_o[g] = START_PC_BASE + START_PC_STRIDE * 32'(g);
    end

    assign bus.nrst_o   = nrst_q;
    assign bus.start_o  = start;
    assign bus.btn_db_o = btn_db_q;
    assign bus.led_o    = led;
    assign bus.state_o  = state_q;
endmodule

// File: tb/tb_ladybird_sys_ctrl.sv
// Bench for ladybird_sys_ctrl: directed scenarios plus randomized buttons,
// soft requests, LED modes and async resets against a timeline-based model.
module tb_ladybird_sys_ctrl;
    localparam int N_CORE = 2, N_BTN = 4, SYNC = 2, RST_HOLD = 8, DB = 4;
    localparam int RST_BTN = 3, HB_LOG2 = 2;

    logic clk = 1'b0;
    logic anrst;
    always #5 clk = ~clk;

    ladybird_sys_ctrl_if #(.N_CORE(N_CORE), .N_BTN(N_BTN)) bus ();

    ladybird_sys_ctrl #(
        .N_CORE(N_CORE), .N_BTN(N_BTN), .SYNC_STAGES(SYNC), .RST_HOLD(RST_HOLD),
        .DEBOUNCE_CYCLES(DB), .RST_BTN(RST_BTN), .HB_LOG2(HB_LOG2)
    ) dut (
        .clk_i(clk), .anrst_i(anrst), .bus(bus)
    );

    int total = 0, bad = 0;

    // Model: time since the last HOLD entry defines the whole sequence.
    bit              m_in_reset;
    int              m_rel, m_t, m_hb;
    bit [N_BTN-1:0]  m_db;
    bit              m_db3_prev;
    bit [N_CORE-1:0] m_started;
    bit [N_BTN-1:0]  smp[$];   // raw button samples, newest first

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_state();
        if (m_in_reset) return 0;
        if (m_t < RST_HOLD) return 1;
        if (m_t == RST_HOLD) return 2;
        if (m_t < RST_HOLD + 1 + N_CORE) return 3;
        return 4;
    endfunction

    function automatic bit exp_nrst();
        return !m_in_reset && (m_t >= RST_HOLD);
    endfunction

    function automatic logic [N_CORE-1:0] exp_start();
        if (exp_state() == 3) return N_CORE'(1 << (m_t - RST_HOLD - 1));
        return '0;
    endfunction

    function automatic logic [N_BTN-1:0] exp_led();
        if (!exp_nrst()) return '0;
        case (bus.led_mode_i)
            2'd0:    return m_db;
            2'd1:    return N_BTN'((m_hb >> HB_LOG2) & 1);
            2'd2:    return N_BTN'(exp_state());
            default: return N_BTN'(m_started);
        endcase
    endfunction

    task automatic model_reset();
        m_in_reset = 1'b1; m_rel = 0; m_t = 0; m_hb = 0;
        m_db = '0; m_db3_prev = 1'b0; m_started = '0;
        smp.delete();
        repeat (SYNC + DB) smp.push_front('0);
    endtask

    task automatic model_edge();
        logic [N_CORE-1:0] st_before;
        bit nrst_before, req, v, same;
        if (!anrst) return;
        st_before   = exp_start();
        nrst_before = exp_nrst();
        req = bus.soft_rst_req_i | (m_db[RST_BTN] & ~m_db3_prev);
        m_db3_prev = m_db[RST_BTN];
        // a level is accepted once the last DB synchronized samples all disagree with it
        for (int b = 0; b < N_BTN; b++) begin
            v = smp[SYNC-1][b];
            same = 1'b1;
            for (int k = SYNC - 1; k <= SYNC + DB - 2; k++) if (smp[k][b] != v) same = 1'b0;
            if (same && (v != m_db[b])) m_db[b] = v;
        end
        smp.push_front(bus.btn_i);
        void'(smp.pop_back());
        if (m_in_reset) begin
            m_rel++;
            if (m_rel >= SYNC) begin m_in_reset = 1'b0; m_t = 0; end
        end else if (req) begin
            m_t = 0;
        end else if (m_t < 1000) begin
            m_t++;
        end
        m_started = exp_nrst() ? (m_started | st_before) : '0;
        m_hb = nrst_before ? ((m_hb + 1) % (1 << (HB_LOG2 + 1))) : 0;
    endtask

    task automatic compare_all();
        chk("state", bus.state_o, exp_state());
        chk("nrst", bus.nrst_o, exp_nrst());
        chk("start", bus.start_o, exp_start());
        chk("btn_db", bus.btn_db_o, m_db);
        chk("led", bus.led_o, exp_led());
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic async_reset(input int cycles);
        anrst = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("arst_start", bus.start_o, 0);
        chk("arst_led", bus.led_o, 0);
        repeat (cycles) cycle();
        anrst = 1'b1;
    endtask

    int e_state, e_nrst, e_start;
    bit found;

    initial begin
        anrst = 1'b0;
        bus.btn_i = '0; bus.soft_rst_req_i = 1'b0; bus.led_mode_i = 2'd3;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_state", bus.state_o, 0);
        chk("rst_nrst", bus.nrst_o, 0);
        chk("rst_start", bus.start_o, 0);
        chk("rst_db", bus.btn_db_o, 0);
        chk("rst_led", bus.led_o, 0);
        chk("pc0", bus.start_pc_o[0], 32'h8000_0000);
        chk("pc1", bus.start_pc_o[1], 32'h8000_1000);

        // Power-up release timeline, checked edge by edge against fixed values
        anrst = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            cycle();
            e_state = (e < 2) ? 0 : (e < 10) ? 1 : (e == 10) ? 2 : (e < 13) ? 3 : 4;
            e_nrst  = (e >= 10) ? 1 : 0;
            e_start = (e == 11) ? 1 : (e == 12) ? 2 : 0;
            chk($sformatf("seq_state_e%0d", e), bus.state_o, e_state);
            chk($sformatf("seq_nrst_e%0d", e), bus.nrst_o, e_nrst);
            chk($sformatf("seq_start_e%0d", e), bus.start_o, e_start);
        end
        chk("led_mode3", bus.led_o, 4'b0011);
        bus.led_mode_i = 2'd2;
        cycle();
        chk("led_mode2", bus.led_o, 4'b0100);
        bus.led_mode_i = 2'd1;
        repeat (16) cycle();

        // Glitch shorter than the debounce window, then a long press
        bus.led_mode_i = 2'd0;
        bus.btn_i[0] = 1'b1;
        repeat (3) cycle();
        bus.btn_i[0] = 1'b0;
        repeat (8) cycle();
        chk("glitch_db0", bus.btn_db_o[0], 0);
        bus.btn_i[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            if (k == 5) chk("db0_early", bus.btn_db_o[0], 0);
        end
        chk("db0_set", bus.btn_db_o[0], 1);
        chk("led0_mode0", bus.led_o[0], 1);
        bus.btn_i[0] = 1'b0;
        repeat (8) cycle();

        // Soft reset from RUN
        bus.soft_rst_req_i = 1'b1;
        cycle();
        chk("soft_nrst", bus.nrst_o, 0);
        bus.soft_rst_req_i = 1'b0;
        repeat (14) cycle();

        // Held reset button: one sequence restart only
        bus.btn_i[RST_BTN] = 1'b1;
        repeat (30) cycle();
        chk("btn3_run", bus.state_o, 4);
        bus.btn_i[RST_BTN] = 1'b0;
        repeat (8) cycle();

        // Soft reset in the cycle core 0 is being woken
        bus.led_mode_i = 2'd3;
        bus.soft_rst_req_i = 1'b1;
        cycle();
        bus.soft_rst_req_i = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (exp_start() == 2'b01) found = 1'b1;
            else cycle();
        end
        chk("wait_start0", found, 1);
        chk("start0_seen", bus.start_o, 2'b01);
        bus.soft_rst_req_i = 1'b1;
        cycle();
        bus.soft_rst_req_i = 1'b0;
        for (int k = 0; k < RST_HOLD; k++) begin
            chk("abandon_start", bus.start_o, 0);
            chk("abandon_led", bus.led_o, 0);
            cycle();
        end
        repeat (6) cycle();

        // Async reset in the fifth HOLD cycle
        bus.soft_rst_req_i = 1'b1;
        cycle();
        bus.soft_rst_req_i = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (exp_state() == 1 && m_t == 4) found = 1'b1;
            else cycle();
        end
        chk("wait_hold5", found, 1);
        async_reset(2);
        repeat (16) cycle();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < N_BTN; b++)
                if ($urandom_range(0, 7) == 0) bus.btn_i[b] = ~bus.btn_i[b];
            bus.soft_rst_req_i = ($urandom_range(0, 29) == 0);
            bus.led_mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) async_reset($urandom_range(0, 3));
            else cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
